// File: rtl/llr_loader.sv
// Streams one codeword of packed LLR words from the input SRAM into the LLR memory, highest address first.
// Latency: reads in cycles 1..W after start, writes trail reads by RD_LAT+1 cycles; no backpressure, fixed-rate.
module llr_loader #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_code,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [63:0]       i_rd_data,
  output logic              o_wen,
  output logic [63:0]       o_data,
  output logic [1:0]        o_code,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [6:0]          cnt_q;
  logic [6:0]          w_last;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_en_q;
  logic [1:0]          code_q;
  logic                done_q;
  logic                err_q;
  logic [RD_LAT-1:0]   vld_q;
  logic                wen_q;
  logic [63:0]         data_q;

  always_comb begin
    w_last = 7'd7;
    case (i_code)
      2'd1:    w_last = 7'd31;
      2'd2:    w_last = 7'd127;
      default: w_last = 7'd7;
    endcase
  end

  // cnt_q is the offset of the word being read this cycle; it counts down to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      code_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_code == 2'd3) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              code_q    <= i_code;
              base_q    <= i_base_addr;
              cnt_q     <= w_last;
              rd_en_q   <= 1'b1;
              rd_addr_q <= i_base_addr + ADDR_W'(w_last);
              state_q   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cnt_q == 7'd0) begin
            state_q <= S_DRAIN;
          end else begin
            cnt_q     <= cnt_q - 7'd1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_q + ADDR_W'(cnt_q - 7'd1);
          end
        end
        S_DRAIN: begin
          // Empty pipe here means the final write is on the bus this cycle.
          if (vld_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      wen_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q[0] <= rd_en_q;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      wen_q <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) begin
        data_q <= i_rd_data;
      end
    end
  end

  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_wen     = wen_q;
  assign o_data    = data_q;
  assign o_code    = code_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_llr_loader.sv
// Bench for llr_loader: two instances (RD_LAT 1 and 3) share stimulus, each checked per cycle against a timing model.
module tb_llr_loader;

  typedef struct packed {
    logic        rd_en;
    logic [11:0] addr;
    logic        wen;
    logic [63:0] data;
    logic [1:0]  code;
    logic        busy;
    logic        done;
    logic        err;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [1:0]  code_i;
  logic [11:0] base_i;

  logic        rd_en   [2];
  logic [11:0] rd_addr [2];
  logic [63:0] rd_data [2];
  logic        wen     [2];
  logic [63:0] wdata   [2];
  logic [1:0]  code_o  [2];
  logic        busy    [2];
  logic        done    [2];
  logic        err     [2];

  logic [63:0] sram [4096];
  logic [63:0] p0;
  logic [63:0] p1 [3];

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_d [2];
  logic [1:0]  cur_code;

  llr_loader #(.ADDR_W(12), .RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code(code_i), .i_base_addr(base_i),
    .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]),
    .o_wen(wen[0]), .o_data(wdata[0]), .o_code(code_o[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
  );

  llr_loader #(.ADDR_W(12), .RD_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code(code_i), .i_base_addr(base_i),
    .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
    .o_wen(wen[1]), .o_data(wdata[1]), .o_code(code_o[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
  );

  // SRAM models: junk on the data bus whenever no read is due, so mistimed captures show up.
  always @(posedge clk) begin
    p0    <= rd_en[0] ? sram[rd_addr[0]] : {$urandom, $urandom};
    p1[0] <= rd_en[1] ? sram[rd_addr[1]] : {$urandom, $urandom};
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd_data[0] = p0;
  assign rd_data[1] = p1[2];

  function automatic int words(logic [1:0] c);
    return (c == 2'd0) ? 8 : (c == 2'd1) ? 32 : 128;
  endfunction

  // Expected outputs in cycle c after a legal start sampled in cycle 0.
  function automatic snap_t model(int i, int c, logic [1:0] code, logic [11:0] base);
    snap_t s;
    int lat = (i == 0) ? 1 : 3;
    int w   = words(code);
    s      = '0;
    s.code = code;
    if (c >= 1 && c <= w) begin
      s.rd_en = 1'b1;
      s.addr  = 12'(base + w - c);
    end
    if (c >= lat + 2 && c <= w + lat + 1) begin
      s.wen  = 1'b1;
      s.data = sram[12'(base + w - 1 - (c - lat - 2))];
    end else begin
      s.data = last_d[i];
    end
    s.busy = (c >= 1 && c <= w + lat + 2);
    s.done = (c == w + lat + 2);
    return s;
  endfunction

  function automatic snap_t act(int i);
    snap_t a;
    a.rd_en = rd_en[i];
    a.addr  = rd_en[i] ? rd_addr[i] : 12'h000;
    a.wen   = wen[i];
    a.data  = wdata[i];
    a.code  = code_o[i];
    a.busy  = busy[i];
    a.done  = done[i];
    a.err   = err[i];
    return a;
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 4096; a++) sram[a] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    snap_t a;
    rst_n  = 1'b0;
    start  = 1'b0;
    code_i = 2'd0;
    base_i = 12'h000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        a = act(i);
        total++;
        if (a !== snap_t'(0)) begin
          bad++;
          $display("FAIL reset inst%0d cyc%0d got=%h want=0", i, c, a);
        end
      end
    end
    last_d[0] = '0;
    last_d[1] = '0;
    cur_code  = 2'd0;
  endtask

  task automatic test_loads();
    logic [1:0]  code;
    logic [11:0] base;
    snap_t       e, a;
    for (int n = 0; n < 9; n++) begin
      if (n == 0) begin
        code = 2'd0; base = 12'h010;
        for (int k = 0; k < 4096; k++) sram[k] = 64'(k);
      end else if (n == 1) begin
        code = 2'd2; base = 12'h000;
        fill_rand();
      end else if (n == 2) begin
        code = 2'd0; base = 12'hFFC;
      end else begin
        code = 2'($urandom_range(0, 2));
        base = 12'($urandom);
        fill_rand();
      end
      @(negedge clk);
      start = 1'b1; code_i = code; base_i = base; cur_code = code;
      for (int c = 1; c <= words(code) + 6; c++) begin
        @(negedge clk);
        start  = 1'b0;
        code_i = 2'($urandom);
        base_i = 12'($urandom);
        for (int i = 0; i < 2; i++) begin
          e = model(i, c, code, base);
          a = act(i);
          total++;
          if (a !== e) begin
            bad++;
            $display("FAIL load%0d inst%0d cyc%0d got=%h want=%h", n, i, c, a, e);
          end
          if (e.wen) last_d[i] = e.data;
        end
      end
      if (n == 0) begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (wdata[i] !== 64'h10) begin
            bad++;
            $display("FAIL llr_entry0 inst%0d got=%h want=%h", i, wdata[i], 64'h10);
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    snap_t e, a;
    @(negedge clk);
    start = 1'b1; code_i = 2'd3; base_i = 12'($urandom);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e      = '0;
        e.code = cur_code;
        e.data = last_d[i];
        e.err  = (c == 1);
        e.done = (c == 1);
        a      = act(i);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL illegal inst%0d cyc%0d got=%h want=%h", i, c, a, e);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [11:0] base = 12'($urandom);
    snap_t       e, a;
    int          ndone [2];
    int          nwen  [2];
    fill_rand();
    ndone[0] = 0; ndone[1] = 0; nwen[0] = 0; nwen[1] = 0;
    @(negedge clk);
    start = 1'b1; code_i = 2'd1; base_i = base; cur_code = 2'd1;
    for (int c = 1; c <= 32 + 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e = model(i, c, 2'd1, base);
        a = act(i);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL busy_ignore inst%0d cyc%0d got=%h want=%h", i, c, a, e);
        end
        if (e.wen) last_d[i] = e.data;
        if (done[i] === 1'b1) ndone[i]++;
        if (wen[i] === 1'b1) nwen[i]++;
      end
      if (c == 10) begin
        start = 1'b1; code_i = 2'd0; base_i = 12'($urandom);
      end
      if (c == 11) start = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ndone[i] != 1 || nwen[i] != 32) begin
        bad++;
        $display("FAIL busy_counts inst%0d got done=%0d wen=%0d want done=1 wen=32", i, ndone[i], nwen[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] base = 12'($urandom);
    snap_t       e, a;
    @(negedge clk);
    start = 1'b1; code_i = 2'd1; base_i = base; cur_code = 2'd1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e = model(i, c, 2'd1, base);
        a = act(i);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL pre_reset inst%0d cyc%0d got=%h want=%h", i, c, a, e);
        end
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int c = 15; c <= 17; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        a = act(i);
        total++;
        if (a !== snap_t'(0)) begin
          bad++;
          $display("FAIL mid_reset inst%0d cyc%0d got=%h want=0", i, c, a);
        end
      end
    end
    rst_n     = 1'b1;
    last_d[0] = '0;
    last_d[1] = '0;
    base      = 12'($urandom);
    @(negedge clk);
    start = 1'b1; code_i = 2'd0; base_i = base; cur_code = 2'd0;
    for (int c = 1; c <= 8 + 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e = model(i, c, 2'd0, base);
        a = act(i);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL post_reset inst%0d cyc%0d got=%h want=%h", i, c, a, e);
        end
        if (e.wen) last_d[i] = e.data;
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_illegal();
    test_busy_ignore();
    test_illegal();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
